// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the decode-stage hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_W       = 5;
  localparam int CNT_W_DEF   = 2;
  localparam int CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_reg_counter.sv
// Saturating pending-write counter for one architectural register.
module hazard_reg_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             full,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX = '1;

  assign zero      = (count == '0);
  assign full      = (count == MAX);
  // Simultaneous inc and dec cancel, so neither is an error.
  assign underflow = dec & ~inc & zero;
  assign overflow  = inc & ~dec & full;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc & ~dec & ~full) begin
      count <= count + CNT_W'(1);
    end else if (dec & ~inc & ~zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard-based RAW/WAW interlock plus branch stall/flush sequencing for decode.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [REG_W-1:0] issue_src1,
  input  logic [REG_W-1:0] issue_src2,
  input  logic             issue_wr,
  input  logic             src1_used,
  input  logic             src2_used,
  input  logic             issue_is_br,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             br_resolve_valid,
  input  logic             br_mispredict,
  output logic             stall_de,
  output logic             stall_fe,
  output logic             flush_de,
  output logic [NREG-1:0]  pending_mask,
  output logic             br_pending,
  output logic             proto_err
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  zero;
  logic [NREG-1:0]  full;
  logic [NREG-1:0]  underflow;
  logic [NREG-1:0]  overflow;
  logic [NREG-1:0]  eff_nz;
  logic [NREG-1:0]  wb_hit;
  logic [NREG-1:0]  wr_hit;
  logic             accept;
  state_t           state;
  state_t           state_next;

  // x0 is hardwired: never pending, never full.
  assign cnt[0]       = '0;
  assign zero[0]      = 1'b1;
  assign full[0]      = 1'b0;
  assign underflow[0] = 1'b0;
  assign overflow[0]  = 1'b0;
  assign eff_nz[0]    = 1'b0;
  assign wb_hit[0]    = 1'b0;
  assign wr_hit[0]    = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      assign wb_hit[gi] = wb_valid & (wb_rd == REG_W'(gi));
      assign wr_hit[gi] = accept & issue_wr & (issue_rd == REG_W'(gi));
      // The register file writes on negedge, so a same-cycle writeback already resolves the RAW.
      assign eff_nz[gi] = ~zero[gi] & ~(wb_hit[gi] & (cnt[gi] == CNT_W'(1)));

      hazard_reg_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (wr_hit[gi]),
        .dec       (wb_hit[gi]),
        .count     (cnt[gi]),
        .zero      (zero[gi]),
        .full      (full[gi]),
        .underflow (underflow[gi]),
        .overflow  (overflow[gi])
      );
    end
  endgenerate

  assign stall_de = issue_valid &
                    ((src1_used & eff_nz[issue_src1]) |
                     (src2_used & eff_nz[issue_src2]) |
                     (issue_wr  & full[issue_rd])     |
                     (state != RUN));
  assign accept   = issue_valid & ~stall_de;

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept & issue_is_br) state_next = BR_WAIT;
      BR_WAIT: if (br_resolve_valid) state_next = br_mispredict ? FLUSH : RUN;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      stall_fe     <= 1'b0;
      br_pending   <= 1'b0;
      flush_de     <= 1'b0;
      pending_mask <= '0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_next;
      stall_fe     <= (state_next == BR_WAIT);
      br_pending   <= (state_next == BR_WAIT);
      flush_de     <= (state_next == FLUSH);
      pending_mask <= ~zero;
      proto_err    <= proto_err | (br_resolve_valid & (state != BR_WAIT)) |
                      (|underflow) | (|overflow);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-002 SHALL have parameter CNT_W, default 2, width of the per-register pending-write counter; CNT_MAX = 2^CNT_W-1.
REQ-003 SHALL have clk, input, 1, clock.
REQ-004 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have issue_valid, input, 1, decode holds a valid instruction.
REQ-006 SHALL have issue_rd / issue_src1 / issue_src2, input, 5 each, destination and source register numbers.
REQ-007 SHALL have issue_wr / src1_used / src2_used, input, 1 each, destination written; sources read.
REQ-008 SHALL have issue_is_br, input, 1, instruction is a branch, JAL or JALR.
REQ-009 SHALL have wb_valid, input, 1, and wb_rd, input, 5, register-file write this cycle.
REQ-010 SHALL have br_resolve_valid, input, 1, and br_mispredict, input, 1, branch outcome from AGEX.
REQ-011 SHALL have stall_de, output, 1, hold decode and insert a bubble.
REQ-012 SHALL have stall_fe, output, 1, and flush_de, output, 1.
REQ-013 SHALL have pending_mask, output, NREG, registered view of cnt!=0 per register.
REQ-014 SHALL have br_pending, output, 1, and proto_err, output, 1 (sticky).

Function
REQ-015 SHALL keep one CNT_W counter per register 1..NREG-1; register 0 is never tracked and never causes a hazard.
REQ-016 SHALL define accept = issue_valid & !stall_de.
REQ-017 On accept & issue_wr & issue_rd!=0, SHALL increment cnt[issue_rd]; on wb_valid & wb_rd!=0, SHALL decrement cnt[wb_rd]; both in the same cycle on the same register SHALL leave the count unchanged.
REQ-018 SHALL compute eff[r] = cnt[r] - (wb_valid & wb_rd==r), because the register file writes on negedge and same-cycle WB data is already visible.
REQ-019 SHALL drive stall_de combinationally = issue_valid & ((src1_used & eff[src1]!=0) | (src2_used & eff[src2]!=0) | (issue_wr & cnt[issue_rd]==CNT_MAX) | state!=RUN), with no extra cycle of latency.
REQ-020 SHALL implement FSM states RUN, BR_WAIT, FLUSH.
REQ-021 RUN: accept & issue_is_br SHALL go to BR_WAIT next cycle.
REQ-022 BR_WAIT: stall_fe=1 and br_pending=1; on br_resolve_valid SHALL go to FLUSH if br_mispredict, else RUN.
REQ-023 FLUSH: exactly one cycle with flush_de=1 and stall_fe=0, then RUN.
REQ-024 br_resolve_valid in RUN or FLUSH SHALL be ignored for state and SHALL set proto_err.
REQ-025 A decrement of a zero counter SHALL hold it at 0 and set proto_err.
REQ-026 An increment of a counter at CNT_MAX SHALL be unreachable because of REQ-019; if it occurs, the counter SHALL hold and proto_err SHALL be set.
REQ-027 pending_mask SHALL update one cycle after the counter change; bit 0 SHALL be constant 0.

Reset
REQ-028 While reset is high, all counters SHALL be 0, state SHALL be RUN, and pending_mask, proto_err, stall_fe, flush_de and br_pending SHALL be 0; all inputs are ignored in that cycle.
REQ-029 Reset mid-operation (any state, any counts) SHALL reach the REQ-028 state in one cycle; stall_de SHALL then depend only on issue_valid and the cleared counters.

Structure
REQ-030 The shared package SHALL hold the FSM state enum (RUN, BR_WAIT, FLUSH), CNT_W/CNT_MAX defaults, and the register-number width from define.vh.
REQ-031 One sub-module, hazard_reg_counter (inc, dec, count, zero/full/underflow flags), SHALL be instantiated per tracked register.

Verification
REQ-032 Issue x5 write, then next cycle read x5 with no WB -> stall_de=1; WB x5 in a later cycle -> stall_de=0 that same cycle, pending_mask[5] clears one cycle later.
REQ-033 Three back-to-back writes to x7 with no WB -> cnt[7]=3; a fourth write to x7 -> stall_de=1 until one WB x7.
REQ-034 Accept BEQ -> BR_WAIT: stall_fe=1; resolve with mispredict=1 -> one cycle flush_de=1, then RUN with stall_fe=0.
REQ-035 Accept JAL, resolve with mispredict=0 -> return to RUN, flush_de never asserts.
REQ-036 WB x9 while cnt[9]=0 -> proto_err=1 and stays 1 until reset; resolve while in RUN -> proto_err=1.
REQ-037 Reset asserted in BR_WAIT with cnt[3]=2 -> next cycle state RUN, pending_mask=0, stall_fe=0.
